// File: rtl/jtag_byte_transmitter.sv
// LSB-first serializer for driving a captured word onto TDO during Shift-DR.
// Loads on the first enabled edge, presents one bit per enabled edge, then parks in DONE until reset.
module jtag_byte_transmitter #(
   parameter int WIDTH = 32
) (
   input  logic             clk_tck,
   input  logic             reset_n,
   input  logic             enable,
   input  logic [WIDTH-1:0] in,
   output logic             out,
   output logic             done
);

   // state | meaning
   // IDLE  | waiting for first enabled edge; out=0
   // SHIFT | presenting shreg[count-1] on out
   // DONE  | all bits presented; out=0, done=1 until reset
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt;
   logic [WIDTH-1:0] shifted;
   logic [CW-1:0]    count, count_nxt;
   logic             out_nxt;
   logic             done_nxt;

   assign shifted = shreg >> count;

   always_ff @(posedge clk_tck or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         shreg <= '0;
         count <= '0;
         out   <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         shreg <= shreg_nxt;
         count <= count_nxt;
         out   <= out_nxt;
         done  <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (enable) begin
         case (state)
            IDLE:    state_nxt = SHIFT;
            SHIFT:   if (count == WIDTH_C) state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // With enable low everything holds, so a paused shift resumes on the same bit.
   always_comb begin
      shreg_nxt = shreg;
      count_nxt = count;
      out_nxt   = out;
      done_nxt  = done;
      if (enable) begin
         case (state)
            IDLE: begin
               shreg_nxt = in;
               out_nxt   = in[0];
               count_nxt = CW'(1);
            end
            SHIFT: begin
               if (count == WIDTH_C) begin
                  out_nxt  = 1'b0;
                  done_nxt = 1'b1;
               end else begin
                  out_nxt   = shifted[0];
                  count_nxt = count + CW'(1);
               end
            end
            DONE: begin
               out_nxt  = 1'b0;
               done_nxt = 1'b1;
            end
            default: begin
               out_nxt  = 1'b0;
               done_nxt = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jtag_byte_transmitter.sv
// Self-checking bench: directed scenarios plus randomized enable/data/reset traffic
// compared against an enabled-edge-count reference model.
module tb_jtag_byte_transmitter;
   localparam int W = 32;

   logic         clk_tck = 1'b0;
   logic         reset_n;
   logic         enable;
   logic [W-1:0] in;
   logic         out;
   logic         done;

   int           n_cmp = 0;
   int           n_err = 0;
   int           n_edge;
   logic [W-1:0] word;

   always #5 clk_tck = ~clk_tck;

   jtag_byte_transmitter #(.WIDTH(W)) dut (
      .clk_tck (clk_tck),
      .reset_n (reset_n),
      .enable  (enable),
      .in      (in),
      .out     (out),
      .done    (done)
   );

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Model: bit k is on out after enabled edge k+1; done after edge W+1.
   task automatic check_outputs(input string tag);
      logic exp_out;
      logic exp_done;
      exp_out  = (n_edge >= 1 && n_edge <= W) ? word[n_edge-1] : 1'b0;
      exp_done = (n_edge >= W + 1);
      chk({tag, "_out"},  W'(out),  W'(exp_out));
      chk({tag, "_done"}, W'(done), W'(exp_done));
   endtask

   task automatic step(input string tag, input logic en, input logic [W-1:0] v);
      enable = en;
      in     = v;
      @(posedge clk_tck);
      if (reset_n && en) begin
         if (n_edge == 0) word = v;
         if (n_edge <= W) n_edge++;
      end
      #1 check_outputs(tag);
   endtask

   task automatic do_reset(input string tag);
      reset_n = 1'b0;
      n_edge  = 0;
      #1 check_outputs({tag, "_async"});
      @(posedge clk_tck);
      @(posedge clk_tck);
      @(negedge clk_tck);
      reset_n = 1'b1;
      #1 check_outputs({tag, "_rel"});
   endtask

   initial begin
      reset_n = 1'b0;
      enable  = 1'b0;
      in      = '0;
      n_edge  = 0;
      word    = '0;

      do_reset("rst");
      for (int i = 0; i < 5; i++) step("rst_idle", 1'b0, $urandom);

      for (int i = 0; i < 36; i++) step("idcode", 1'b1, 32'h000FAF01);
      chk("idcode_last_bit_seen", W'(n_edge), W'(W + 1));

      do_reset("pause_rst");
      for (int i = 0; i < 5; i++) step("pause_pre", 1'b1, 32'h000FAF01);
      chk("pause_hold_bit4", W'(out), W'(1'b0));
      for (int i = 0; i < 3; i++) step("pause_off", 1'b0, $urandom);
      for (int i = 0; i < 30; i++) step("pause_post", 1'b1, $urandom);

      do_reset("mid_rst0");
      for (int i = 0; i < 10; i++) step("mid_pre", 1'b1, 32'h000FAF01);
      #2;
      do_reset("mid_rst");
      step("mid_e1", 1'b1, 32'h000FAF01);
      chk("mid_e1_bit0", W'(out), W'(1'b1));

      do_reset("chg_rst");
      step("chg_load", 1'b1, 32'hFFFFFFFF);
      for (int i = 0; i < 33; i++) step("chg", 1'b1, 32'h0);

      do_reset("rearm_rst");
      for (int i = 0; i < 33; i++) step("rearm", 1'b1, 32'h80000000);
      chk("rearm_done", W'(done), W'(1'b1));

      for (int t = 0; t < 12; t++) begin
         do_reset("rnd_rst");
         for (int c = 0; c < 80; c++) begin
            if ($urandom_range(0, 99) == 0) begin
               #2;
               do_reset("rnd_midrst");
            end
            step("rnd", ($urandom_range(0, 3) != 0), $urandom);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
